// File: rtl/axis_insert_header_arbiter_pkg.sv
// Shared types and default widths for the header-insert arbiter.
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_e;

    localparam int DEF_DATA_WD = 32;
    localparam int DEF_N_SRC   = 2;

endpackage

// File: rtl/axis_insert_header_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_SRC  = 2,
    parameter int SRC_WD = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0]  req,
    input  logic [SRC_WD-1:0] ptr,
    output logic [SRC_WD-1:0] gnt_idx,
    output logic              gnt_any
);

    logic [SRC_WD-1:0] idx;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int off = 0; off < N_SRC; off++) begin
            idx = SRC_WD'((int'(ptr) + off) % N_SRC);
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/axis_insert_header_arbiter.sv
// Packet-level round-robin arbiter sharing one header-insert datapath between
// N_SRC sources: header beat first, then the body up to last, then re-arbitrate.
module axis_insert_header_arbiter
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = DEF_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int N_SRC        = DEF_N_SRC,
    parameter int SRC_WD       = $clog2(N_SRC)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_SRC-1:0]                     valid_in,
    input  logic [N_SRC-1:0][DATA_WD-1:0]        data_in,
    input  logic [N_SRC-1:0][DATA_BYTE_WD-1:0]   keep_in,
    input  logic [N_SRC-1:0]                     last_in,
    output logic [N_SRC-1:0]                     ready_in,
    input  logic [N_SRC-1:0]                     valid_insert,
    input  logic [N_SRC-1:0][DATA_WD-1:0]        data_insert,
    input  logic [N_SRC-1:0][DATA_BYTE_WD-1:0]   keep_insert,
    input  logic [N_SRC-1:0][BYTE_CNT_WD-1:0]    byte_insert_cnt,
    output logic [N_SRC-1:0]                     ready_insert,
    output logic                                 dn_valid_in,
    output logic [DATA_WD-1:0]                   dn_data_in,
    output logic [DATA_BYTE_WD-1:0]              dn_keep_in,
    output logic                                 dn_last_in,
    input  logic                                 dn_ready_in,
    output logic                                 dn_valid_insert,
    output logic [DATA_WD-1:0]                   dn_data_insert,
    output logic [DATA_BYTE_WD-1:0]              dn_keep_insert,
    output logic [BYTE_CNT_WD-1:0]               dn_byte_insert_cnt,
    input  logic                                 dn_ready_insert,
    output logic [SRC_WD-1:0]                    grant_id,
    output logic                                 busy
);

    state_e            state, state_nx;
    logic [SRC_WD-1:0] grant, rr_ptr, arb_idx, ptr_nx;
    logic              arb_any, hdr_hs, last_hs;

    rr_arbiter #(.N_SRC(N_SRC), .SRC_WD(SRC_WD)) u_rr (
        .req     (valid_insert),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign hdr_hs  = (state == HDR)  && valid_insert[grant] && dn_ready_insert;
    assign last_hs = (state == BODY) && valid_in[grant] && dn_ready_in && last_in[grant];
    assign ptr_nx  = (grant == SRC_WD'(N_SRC - 1)) ? '0 : grant + SRC_WD'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && arb_any) grant <= arb_idx;
            // Pointer moves past the finished source so the next IDLE favours the others.
            if (last_hs) rr_ptr <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arb_any) state_nx = HDR;
            HDR:     if (hdr_hs)  state_nx = BODY;
            BODY:    if (last_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pure pass-through: payload always follows the grant, only valid/ready are gated.
    always_comb begin
        ready_in           = '0;
        ready_insert       = '0;
        dn_valid_in        = 1'b0;
        dn_last_in         = 1'b0;
        dn_valid_insert    = 1'b0;
        dn_data_in         = data_in[grant];
        dn_keep_in         = keep_in[grant];
        dn_data_insert     = data_insert[grant];
        dn_keep_insert     = keep_insert[grant];
        dn_byte_insert_cnt = byte_insert_cnt[grant];
        case (state)
            HDR: begin
                dn_valid_insert     = valid_insert[grant];
                ready_insert[grant] = dn_ready_insert;
            end
            BODY: begin
                dn_valid_in     = valid_in[grant];
                dn_last_in      = last_in[grant];
                ready_in[grant] = dn_ready_in;
            end
            default: ;
        endcase
    end

    assign grant_id = grant;
    assign busy     = (state != IDLE);

endmodule
